seq_mul_unit: RTL and testbench
===============================

SEQ_MUL_UNIT -- requirements
Module: seq_mul_unit

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range 2..64.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to multiply; accepted only in IDLE.
REQ-005 a_in  input  WIDTH  multiplicand; sampled on the accepting edge.
REQ-006 b_in  input  WIDTH  multiplier; sampled on the accepting edge.
REQ-007 tc  input  1  two's-complement mode select; sampled on the accepting edge; present only when SEQ_MUL_SIGNED_EN is defined.
REQ-008 busy  output  1  high while in CALC.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 product  output  2*WIDTH  result register; holds its value until the next accepted start.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-012 IDLE with start=1: on the edge, A<=zero-extended a_in (2*WIDTH bits), B<=b_in, product<=0, state<=CALC.
REQ-013 In CALC, eqz = (B==0) SHALL be combinational; if eqz, state<=DONE and no register updates.
REQ-014 In CALC with eqz=0: if B[0], product<=product+A; then A<=A<<1 and B<=B>>1 (logical shift).
REQ-015 Addition SHALL be 2*WIDTH bits wide; it cannot overflow.
REQ-016 DONE SHALL assert done for exactly one cycle, then state<=IDLE unconditionally.
REQ-017 Latency SHALL be k+2 cycles from the accepting edge to done high, where k = index of the MSB set in b_in plus 1 (k=0 for b_in=0); the maximum is WIDTH+2.
REQ-018 start SHALL be ignored in CALC and DONE; there is no queuing.
REQ-019 busy SHALL be 0 in IDLE and DONE; done SHALL be 0 in IDLE and CALC.

Reset
REQ-020 rst_n low SHALL force, asynchronously: state=IDLE, busy=0, done=0, product=0, A=0, B=0.
REQ-021 Reset in mid-CALC SHALL abort the operation with no done pulse; the first start after release SHALL be processed normally.

Configuration
REQ-022 Macro SEQ_MUL_SIGNED_EN defined: tc port present.
- tc=1 at acceptance: A and B load with the magnitudes of a_in and b_in.
- The sign flag sign_q<=a_in[MSB]^b_in[MSB] is registered at acceptance.
- On the CALC->DONE edge, product<=-product if sign_q=1.
- A magnitude of 2^(WIDTH-1) SHALL be handled correctly.
REQ-023 tc=0 with the macro defined SHALL behave identically to the unsigned build.
REQ-024 Macro undefined: no tc port, no sign_q register, unsigned operation only.

Structure
REQ-025 Package seq_mul_pkg SHALL hold the state enum type (IDLE/CALC/DONE) and its encoding constants.
REQ-026 Registers A, B and product, the adder and the eqz compare SHALL live in sub-module seq_mul_dp.
- seq_mul_dp is controlled by ld, clr, shift and add_en strobes from the FSM in seq_mul_unit.
- seq_mul_dp returns eqz and B[0] to the FSM.

Verification (WIDTH=16)
REQ-027 a=3, b=5, start pulse -> busy for 4 cycles, done high at cycle 5 after acceptance, product=0x0000000F.
REQ-028 a=0x1234, b=0 -> done at cycle 2, product=0.
REQ-029 a=0xFFFF, b=0xFFFF -> done at cycle 18, product=0xFFFE0001.
REQ-030 a=7, b=9 accepted; start held high with a=2, b=2 during CALC -> ignored, product=0x0000003F; a new start after done returns 4.
REQ-031 a=100, b=0x8000; rst_n pulsed low in the 5th CALC cycle -> busy, done and product all 0 immediately, no done pulse; then a=6, b=7 -> product=42.
REQ-032 (SEQ_MUL_SIGNED_EN defined) tc=1:
- a=0xFFFD (-3), b=5 -> product=0xFFFFFFF1.
- a=0x8000, b=0x8000 -> product=0x40000000.
- tc=0, a=0xFFFD, b=5 -> product=0x0004FFF1.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// Shared types for the shift-add multiplier: FSM state encoding.
package seq_mul_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/seq_mul_dp.sv
// Shift-add datapath: multiplicand A (double width), multiplier B, product
// accumulator, the accumulate adder and the B==0 detector.
module seq_mul_dp #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld,       // load A/B from operands
  input  logic               clr,      // zero the product
  input  logic               shift,    // one shift-add step
  input  logic               add_en,   // accumulate A on this step
  input  logic               neg,      // two's-complement the product
  input  logic [WIDTH-1:0]   a_ld,
  input  logic [WIDTH-1:0]   b_ld,
  output logic               eqz,
  output logic               b_lsb,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  assign eqz     = (b_q == '0);
  assign b_lsb   = b_q[0];
  assign product = prod_q;

  // Next-state for the datapath registers; everything holds unless strobed.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    prod_d = prod_q;
    if (ld) begin
      a_d = {{WIDTH{1'b0}}, a_ld};
      b_d = b_ld;
    end
    if (clr) prod_d = '0;
    if (shift) begin
      // Full 2*WIDTH sum: A*B fits in 2*WIDTH bits, so no carry is lost.
      if (add_en) prod_d = prod_q + a_q;
      a_d = a_q << 1;
      b_d = b_q >> 1;
    end
    if (neg) prod_d = -prod_q;
  end

  // Datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      prod_q <= prod_d;
    end
  end

endmodule

// File: rtl/seq_mul_unit.sv
// Sequential shift-add multiplier: IDLE -> CALC (one multiplier bit per
// cycle, exits early once B is exhausted) -> DONE (one-cycle pulse).
// Optional signed mode: define SEQ_MUL_SIGNED_EN to add the tc port; the
// operands are then multiplied as magnitudes and the result negated on exit.
module seq_mul_unit
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic               tc,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_e state_q, state_d;
  logic ld, clr, shift, add_en, neg;
  logic eqz, b_lsb;
  logic [WIDTH-1:0] a_op, b_op;

`ifdef SEQ_MUL_SIGNED_EN
  logic sign_q, sign_d;
  // Magnitudes; -(2^(WIDTH-1)) wraps to itself, which is the correct
  // unsigned magnitude once zero-extended in the datapath.
  assign a_op = (tc && a_in[WIDTH-1]) ? -a_in : a_in;
  assign b_op = (tc && b_in[WIDTH-1]) ? -b_in : b_in;
`else
  assign a_op = a_in;
  assign b_op = b_in;
`endif

  // Next-state and datapath strobes.
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    clr     = 1'b0;
    shift   = 1'b0;
    add_en  = 1'b0;
    neg     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
    sign_d  = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          ld      = 1'b1;
          clr     = 1'b1;
          state_d = CALC;
`ifdef SEQ_MUL_SIGNED_EN
          sign_d  = tc & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
`endif
        end
      end
      CALC: begin
        busy = 1'b1;
        if (eqz) begin
          state_d = DONE;
`ifdef SEQ_MUL_SIGNED_EN
          neg     = sign_q;
`endif
        end else begin
          shift  = 1'b1;
          add_en = b_lsb;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register (and sign flag in signed builds).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
`ifdef SEQ_MUL_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef SEQ_MUL_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  seq_mul_dp #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (ld),
    .clr     (clr),
    .shift   (shift),
    .add_en  (add_en),
    .neg     (neg),
    .a_ld    (a_op),
    .b_ld    (b_op),
    .eqz     (eqz),
    .b_lsb   (b_lsb),
    .product (product)
  );

endmodule

// File: tb/tb_seq_mul_unit.sv
// Directed bench for seq_mul_unit (WIDTH=16). Cycle numbering: the accepting
// edge is cycle 1; "done at cycle n" means done is high after the n-th edge.
module tb_seq_mul_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        tc = 1'b0;
  logic        busy, done;
  logic [31:0] product;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_mul_unit #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
`ifdef SEQ_MUL_SIGNED_EN
    .tc      (tc),
`endif
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // One multiply; hold=1 keeps start high with a=2,b=2 while it runs.
  task automatic mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input bit hold, input logic [31:0] ep, input int elat, input int ebusy);
    int lat, nbusy;
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    nbusy = busy ? 1 : 0;
    if (hold) begin a_in = 16'd2; b_in = 16'd2; end
    else start = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) nbusy++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_busy"}, nbusy, ebusy);
    chk({tag, "_prod"}, product, ep);
    @(posedge clk); #1;
    chk({tag, "_done1cyc"}, {busy, done}, 2'b00);
    chk({tag, "_hold"}, product, ep);
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_prod", product, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // 3*5: k=3 -> busy 4, done at cycle 5
    mul("m3x5", 16'd3, 16'd5, 1'b0, 32'h0000000F, 5, 4);
    // b=0: k=0 -> done at cycle 2
    mul("mb0", 16'h1234, 16'h0000, 1'b0, 32'h0, 2, 1);
    // max latency
    mul("mff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 18, 17);
    // start held during CALC must be ignored; 9 -> k=4
    mul("mhold", 16'd7, 16'd9, 1'b1, 32'h0000003F, 6, 5);
    mul("m2x2", 16'd2, 16'd2, 1'b0, 32'h4, 4, 3);

    // Abort in the 5th CALC cycle via async reset
    @(negedge clk);
    a_in = 16'd100; b_in = 16'h8000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_prod", product, 32'h0);
    begin
      int seen = 0;
      repeat (3) begin @(posedge clk); #1; if (done) seen++; end
      @(negedge clk); rst_n = 1'b1;
      repeat (20) begin @(posedge clk); #1; if (done || busy) seen++; end
      chk("abort_nodone", seen, 0);
    end
    mul("m6x7", 16'd6, 16'd7, 1'b0, 32'd42, 5, 4);

`ifdef SEQ_MUL_SIGNED_EN
    tc = 1'b1;
    mul("s_m3x5", 16'hFFFD, 16'd5, 1'b0, 32'hFFFFFFF1, 5, 4);
    mul("s_min", 16'h8000, 16'h8000, 1'b0, 32'h40000000, 18, 17);
    tc = 1'b0;
    mul("u_fffd", 16'hFFFD, 16'd5, 1'b0, 32'h0004FFF1, 5, 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
